// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, clocked at the bit rate.
// Each clk_br cycle is one bit period. Frame: start, DATA_BITS data bits
// (LSB first), optional parity bit, STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_br,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx_ready,
    output logic                 serial_data,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_nxt;
    logic                 r_tx_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    // Transmit FSM and datapath
    state_e               r_state;
    state_e               w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [BIT_W-1:0]     w_bit_cnt_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic                 r_serial;
    logic                 w_serial_nxt;
    logic                 r_tx_busy;
    logic                 r_tx_done;
    logic                 w_done_nxt;
    logic                 w_bit_last;
    logic                 w_stop_last;

    assign w_push      = tx_start && r_tx_ready;
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];
    // Odd parity is the complement of the plain XOR used for even parity.
    assign w_head_par  = (PARITY == 2) ? ~(^w_head) : (^w_head);
    assign w_bit_last  = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
    assign w_stop_last = (r_bit_cnt == BIT_W'(STOP_BITS - 1));

    assign tx_ready    = r_tx_ready;
    assign serial_data = r_serial;
    assign tx_busy     = r_tx_busy;
    assign tx_done     = r_tx_done;

    // Next FIFO occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO pointers, occupancy and the full flag derived from the next count.
    always_ff @(posedge clk_br) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_tx_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // FIFO data array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk_br) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_br) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; unknown encodings fall back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_last) begin
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_stop_last) begin
                    w_state_nxt = w_empty ? S_IDLE : S_START;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM output logic: next line value, FIFO pop, shifter and bit counter.
    always_comb begin
        w_serial_nxt  = 1'b1;
        w_done_nxt    = 1'b0;
        w_pop         = 1'b0;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_par_nxt     = r_par;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_head;
                    w_par_nxt     = w_head_par;
                    w_bit_cnt_nxt = '0;
                    w_serial_nxt  = 1'b0;
                end
            end
            S_START: begin
                w_serial_nxt  = r_shift[0];
                w_shift_nxt   = r_shift >> 1;
                w_bit_cnt_nxt = '0;
            end
            S_DATA: begin
                if (w_bit_last) begin
                    w_bit_cnt_nxt = '0;
                    w_serial_nxt  = (PARITY != 0) ? r_par : 1'b1;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    w_serial_nxt  = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                end
            end
            S_PARITY: begin
                w_bit_cnt_nxt = '0;
                w_serial_nxt  = 1'b1;
            end
            S_STOP: begin
                if (w_stop_last) begin
                    w_done_nxt    = 1'b1;
                    w_bit_cnt_nxt = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_head;
                        w_par_nxt    = w_head_par;
                        w_serial_nxt = 1'b0;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    w_serial_nxt  = 1'b1;
                end
            end
            default: begin
                w_bit_cnt_nxt = '0;
                w_serial_nxt  = 1'b1;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_br) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par     <= 1'b0;
            r_serial  <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_par     <= w_par_nxt;
            r_serial  <= w_serial_nxt;
            r_tx_busy <= (w_state_nxt != S_IDLE);
            r_tx_done <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different frame formats.
// Stimulus queues hand-written expected line frames (bit 0 = first bit on
// the line); per-instance monitors rebuild frames from serial_data and
// compare them, and check tx_busy/tx_done around every frame.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  rst_v;
    logic [3:0]  start_v;
    logic [7:0]  din_v [4];
    logic [3:0]  ready_v;
    logic [3:0]  serial_v;
    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [11:0] exp_q [4][$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // dut0: 8N1, dut1: 8E1, dut2: 8O1, dut3: 8E2
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned PAR  = (g == 1 || g == 3) ? 1 : ((g == 2) ? 2 : 0);
        localparam int unsigned STOP = (g == 3) ? 2 : 1;
        localparam int          FLEN = (g == 0) ? 10 : ((g == 3) ? 12 : 11);

        uart_tx_fifo #(
            .DATA_BITS (8),
            .FIFO_DEPTH(4),
            .PARITY    (PAR),
            .STOP_BITS (STOP)
        ) u_dut (
            .clk_br     (clk),
            .rst        (rst_v[g]),
            .tx_start   (start_v[g]),
            .data_in    (din_v[g]),
            .tx_ready   (ready_v[g]),
            .serial_data(serial_v[g]),
            .tx_busy    (busy_v[g]),
            .tx_done    (done_v[g])
        );

        int          pos;
        logic        done_pend;
        logic [11:0] frame;

        // Line monitor: rebuild each frame and score it against the queue.
        initial begin
            pos       = -1;
            done_pend = 1'b0;
            frame     = '0;
            forever begin
                @(negedge clk);
                if (rst_v[g]) begin
                    pos       = -1;
                    done_pend = 1'b0;
                    frame     = '0;
                end else begin
                    check($sformatf("dut%0d tx_done", g), 12'(done_v[g]), 12'(done_pend));
                    done_pend = 1'b0;
                    if (pos < 0 && serial_v[g] === 1'b0) begin
                        pos = 0;
                    end
                    if (pos >= 0) begin
                        check($sformatf("dut%0d tx_busy in frame", g), 12'(busy_v[g]), 12'h1);
                        frame[pos] = serial_v[g];
                        pos++;
                        if (pos == FLEN) begin
                            if (exp_q[g].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL dut%0d unexpected frame: got 0x%0h, expected none", g, frame);
                            end else begin
                                check($sformatf("dut%0d frame", g), frame, exp_q[g].pop_front());
                            end
                            pos       = -1;
                            done_pend = 1'b1;
                            frame     = '0;
                        end
                    end else begin
                        check($sformatf("dut%0d tx_busy idle", g), 12'(busy_v[g]), 12'h0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int g, input logic [7:0] d);
        start_v[g] = 1'b1;
        din_v[g]   = d;
        tick();
    endtask

    // Wait for all queued frames of one instance to appear, bounded.
    task automatic drain(input int g, input int budget);
        int n;
        n = 0;
        while ((exp_q[g].size() != 0 || busy_v[g] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL dut%0d drain timeout: got %0d frames pending, expected 0", g, exp_q[g].size());
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tdone [3];
        int nd;
        int t;

        rst_v   = 4'hF;
        start_v = 4'h0;
        for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
        repeat (3) tick();
        rst_v = 4'h0;

        // Reset values and idle line
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int g = 0; g < 4; g++) begin
                check($sformatf("dut%0d idle serial", g), 12'(serial_v[g]), 12'h1);
                check($sformatf("dut%0d idle ready", g), 12'(ready_v[g]), 12'h1);
            end
        end

        // 0xA5, 8N1: line 0,1,0,1,0,0,1,0,1,1 starting two edges after the write
        tick();
        exp_q[0].push_back(12'h34A);
        put(0, 8'hA5);
        start_v[0] = 1'b0;
        @(negedge clk);
        check("latency: still idle after write edge", 12'(serial_v[0]), 12'h1);
        @(negedge clk);
        check("latency: start bit", 12'(serial_v[0]), 12'h0);
        drain(0, 100);

        // 0x11, 0x22, 0x33 back to back: done pulses 10 cycles apart
        tick();
        exp_q[0].push_back(12'h222);
        exp_q[0].push_back(12'h244);
        exp_q[0].push_back(12'h266);
        put(0, 8'h11);
        put(0, 8'h22);
        put(0, 8'h33);
        start_v[0] = 1'b0;
        nd = 0;
        t  = 0;
        while (nd < 3 && t < 100) begin
            @(negedge clk);
            t++;
            if (done_v[0] === 1'b1) begin
                tdone[nd] = t;
                nd++;
            end
        end
        check("burst tx_done count", 12'(nd), 12'd3);
        if (nd == 3) begin
            check("burst done spacing 1-2", 12'(tdone[1] - tdone[0]), 12'd10);
            check("burst done spacing 2-3", 12'(tdone[2] - tdone[1]), 12'd10);
        end
        drain(0, 100);

        // Six writes on consecutive cycles: FIFO fills, sixth byte dropped
        tick();
        exp_q[0].push_back(12'h202);
        exp_q[0].push_back(12'h204);
        exp_q[0].push_back(12'h208);
        exp_q[0].push_back(12'h210);
        exp_q[0].push_back(12'h220);
        put(0, 8'h01);
        put(0, 8'h02);
        put(0, 8'h04);
        put(0, 8'h08);
        check("ready before fifo full", 12'(ready_v[0]), 12'h1);
        put(0, 8'h10);
        check("ready low when fifo full", 12'(ready_v[0]), 12'h0);
        put(0, 8'h20);
        start_v[0] = 1'b0;
        check("ready low after dropped write", 12'(ready_v[0]), 12'h0);
        drain(0, 200);

        // Even parity, 0x07 -> parity 1; 0x03 -> parity 0
        tick();
        exp_q[1].push_back(12'h60E);
        exp_q[1].push_back(12'h406);
        put(1, 8'h07);
        put(1, 8'h03);
        start_v[1] = 1'b0;
        drain(1, 100);

        // Odd parity, 0x07 -> parity 0; 0x03 -> parity 1
        tick();
        exp_q[2].push_back(12'h40E);
        exp_q[2].push_back(12'h606);
        put(2, 8'h07);
        put(2, 8'h03);
        start_v[2] = 1'b0;
        drain(2, 100);

        // Even parity with two stop bits: 12-cycle frames
        tick();
        exp_q[3].push_back(12'hCB4);
        exp_q[3].push_back(12'hF00);
        put(3, 8'h5A);
        put(3, 8'h80);
        start_v[3] = 1'b0;
        drain(3, 100);

        // Reset during data bit 3 of 0xFF with two bytes queued
        tick();
        put(0, 8'hFF);
        put(0, 8'h5A);
        put(0, 8'h3C);
        start_v[0] = 1'b0;
        tick();
        tick();
        tick();
        check("data bit 3 of 0xFF", 12'(serial_v[0]), 12'h1);
        check("busy during frame", 12'(busy_v[0]), 12'h1);
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        @(negedge clk);
        check("rst: line high", 12'(serial_v[0]), 12'h1);
        check("rst: not busy", 12'(busy_v[0]), 12'h0);
        check("rst: no tx_done", 12'(done_v[0]), 12'h0);
        check("rst: ready", 12'(ready_v[0]), 12'h1);
        repeat (30) @(negedge clk);
        check("rst: still idle", 12'(busy_v[0]), 12'h0);

        for (int g = 0; g < 4; g++) begin
            check($sformatf("dut%0d frames outstanding", g), 12'(exp_q[g].size()), 12'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
